// File: rtl/tdm_demux_4ch_4bit.sv
// Receive-side TDM demultiplexer: rebuilds 4-slot frames into parallel channel registers,
// tracks frame alignment and counts alignment violations.
module tdm_demux_4ch_4bit #(
    parameter int WIDTH     = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_sof,
    output logic [WIDTH-1:0]     out_a,
    output logic [WIDTH-1:0]     out_b,
    output logic [WIDTH-1:0]     out_c,
    output logic [WIDTH-1:0]     out_d,
    output logic                 out_valid,
    output logic                 locked,
    output logic [1:0]           slot,
    output logic                 sync_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [1:0]            slot_q, slot_d;
    logic                  locked_q, locked_d;
    logic [WIDTH-1:0]      shadow0_q, shadow0_d;
    logic [WIDTH-1:0]      shadow1_q, shadow1_d;
    logic [WIDTH-1:0]      shadow2_q, shadow2_d;
    logic [WIDTH-1:0]      out_a_q, out_a_d;
    logic [WIDTH-1:0]      out_b_q, out_b_d;
    logic [WIDTH-1:0]      out_c_q, out_c_d;
    logic [WIDTH-1:0]      out_d_q, out_d_d;
    logic                  out_valid_q, out_valid_d;
    logic                  sync_err_q, sync_err_d;
    logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        locked_d    = locked_q;
        shadow0_d   = shadow0_q;
        shadow1_d   = shadow1_q;
        shadow2_d   = shadow2_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        out_c_d     = out_c_q;
        out_d_d     = out_d_q;
        out_valid_d = 1'b0;
        sync_err_d  = 1'b0;
        err_cnt_d   = err_cnt_q;

        if (in_valid) begin
            if (state_q == HUNT) begin
                if (in_sof) begin
                    shadow0_d = in_data;
                    slot_d    = 2'd1;
                    locked_d  = 1'b1;
                    state_d   = LOCKED;
                end
            end else if (in_sof) begin
                // An SOF anywhere but slot 0 abandons the partial frame and restarts here.
                shadow0_d  = in_data;
                slot_d     = 2'd1;
                sync_err_d = (slot_q != 2'd0);
            end else begin
                case (slot_q)
                    2'd0: begin
                        sync_err_d = 1'b1;
                        locked_d   = 1'b0;
                        slot_d     = 2'd0;
                        state_d    = HUNT;
                    end
                    2'd1: begin
                        shadow1_d = in_data;
                        slot_d    = 2'd2;
                    end
                    2'd2: begin
                        shadow2_d = in_data;
                        slot_d    = 2'd3;
                    end
                    default: begin
                        out_a_d     = shadow0_q;
                        out_b_d     = shadow1_q;
                        out_c_d     = shadow2_q;
                        out_d_d     = in_data;
                        out_valid_d = 1'b1;
                        slot_d      = 2'd0;
                    end
                endcase
            end
        end

        if (sync_err_d && (err_cnt_q != {ERR_CNT_W{1'b1}}))
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            slot_q      <= 2'd0;
            locked_q    <= 1'b0;
            shadow0_q   <= '0;
            shadow1_q   <= '0;
            shadow2_q   <= '0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_c_q     <= '0;
            out_d_q     <= '0;
            out_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            locked_q    <= locked_d;
            shadow0_q   <= shadow0_d;
            shadow1_q   <= shadow1_d;
            shadow2_q   <= shadow2_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_c_q     <= out_c_d;
            out_d_q     <= out_d_d;
            out_valid_q <= out_valid_d;
            sync_err_q  <= sync_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign out_c     = out_c_q;
    assign out_d     = out_d_q;
    assign out_valid = out_valid_q;
    assign locked    = locked_q;
    assign slot      = slot_q;
    assign sync_err  = sync_err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_tdm_demux_4ch_4bit.sv
// Testbench for tdm_demux_4ch_4bit: directed frame scenarios plus random beats,
// compared every cycle against a frame-collecting reference model.
module tb_tdm_demux_4ch_4bit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = 4'd0;
    logic       in_sof = 1'b0;
    logic [3:0] out_a, out_b, out_c, out_d;
    logic       out_valid, locked, sync_err;
    logic [1:0] slot;
    logic [7:0] err_cnt;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model state: beats of the frame being collected, last full frame.
    int  m_frame[$];
    int  m_out[4];
    bit  m_locked;
    bit  m_vld;
    bit  m_err;
    int  m_cnt;

    tdm_demux_4ch_4bit #(.WIDTH(4), .ERR_CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_sof(in_sof),
        .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_d(out_d),
        .out_valid(out_valid), .locked(locked), .slot(slot),
        .sync_err(sync_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_frame.delete();
        for (int i = 0; i < 4; i++) m_out[i] = 0;
        m_locked = 0;
        m_vld = 0;
        m_err = 0;
        m_cnt = 0;
    endtask

    task automatic model_beat(input bit v, input bit s, input int d);
        m_vld = 0;
        m_err = 0;
        if (!v) return;
        if (!m_locked) begin
            if (s) begin
                m_frame = '{d};
                m_locked = 1;
            end
        end else if (s) begin
            if (m_frame.size() != 0) m_err = 1;
            m_frame = '{d};
        end else if (m_frame.size() == 0) begin
            m_err = 1;
            m_locked = 0;
        end else begin
            m_frame.push_back(d);
            if (m_frame.size() == 4) begin
                for (int i = 0; i < 4; i++) m_out[i] = m_frame[i];
                m_vld = 1;
                m_frame.delete();
            end
        end
        if (m_err && m_cnt < 255) m_cnt++;
    endtask

    task automatic check_all();
        chk("out_a", out_a, m_out[0]);
        chk("out_b", out_b, m_out[1]);
        chk("out_c", out_c, m_out[2]);
        chk("out_d", out_d, m_out[3]);
        chk("out_valid", out_valid, m_vld);
        chk("locked", locked, m_locked);
        chk("slot", slot, m_frame.size());
        chk("sync_err", sync_err, m_err);
        chk("err_cnt", err_cnt, m_cnt);
    endtask

    task automatic step(input bit v, input bit s, input int d);
        in_valid = v;
        in_sof   = s;
        in_data  = d[3:0];
        @(posedge clk);
        model_beat(v, s, d);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        check_all();
        rst_n = 1'b1;
    endtask

    task automatic frame4(input int a, input int b, input int c, input int d);
        step(1, 1, a);
        step(1, 0, b);
        step(1, 0, c);
        step(1, 0, d);
    endtask

    initial begin
        int pos;
        bit s;
        @(posedge clk);
        #1;
        do_reset();
        chk("rst_locked", locked, 0);
        chk("rst_err_cnt", err_cnt, 0);

        // Basic frame
        frame4(1, 2, 3, 4);
        chk("f1_abcd", {out_a, out_b, out_c, out_d}, 16'h1234);
        chk("f1_valid", out_valid, 1);
        chk("f1_slot", slot, 0);
        step(0, 0, 0);
        chk("f1_valid_drop", out_valid, 0);

        // HUNT ignores non-SOF beats
        do_reset();
        step(1, 0, 4'hF);
        step(1, 0, 4'hE);
        chk("hunt_ignore", locked, 0);
        frame4(5, 6, 7, 8);
        chk("hunt_frame", {out_a, out_b, out_c, out_d}, 16'h5678);
        chk("hunt_errcnt", err_cnt, 0);

        // Early SOF
        do_reset();
        step(1, 1, 1);
        step(1, 0, 2);
        step(1, 1, 9);
        chk("early_err", sync_err, 1);
        chk("early_cnt", err_cnt, 1);
        chk("early_novalid", out_valid, 0);
        step(1, 0, 4'hA);
        step(1, 0, 4'hB);
        step(1, 0, 4'hC);
        chk("early_frame", {out_a, out_b, out_c, out_d}, 16'h9ABC);

        // Missing SOF
        frame4(1, 2, 3, 4);
        step(1, 0, 5);
        chk("miss_err", sync_err, 1);
        chk("miss_unlock", locked, 0);
        chk("miss_hold", {out_a, out_b, out_c, out_d}, 16'h1234);

        // Idle gaps between beats
        step(1, 1, 3); step(0, 0, 0);
        step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
        step(1, 0, 4'hF); step(0, 0, 0);
        step(1, 0, 6);
        chk("gap_frame", {out_a, out_b, out_c, out_d}, 16'h30F6);
        chk("gap_valid", out_valid, 1);
        step(0, 0, 0);

        // Reset mid-frame
        step(1, 1, 2);
        step(1, 0, 2);
        do_reset();
        chk("midrst_out", {out_a, out_b, out_c, out_d}, 0);
        frame4(7, 7, 7, 7);
        chk("midrst_frame", {out_a, out_b, out_c, out_d}, 16'h7777);

        // Saturating error counter: repeated SOF beats each break a one-beat frame
        for (int i = 0; i < 301; i++) step(1, 1, i & 15);
        chk("err_sat", err_cnt, 255);

        // Random beats, mostly well-formed with occasional SOF corruption
        pos = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                step(0, $urandom_range(0, 1), $urandom_range(0, 15));
            end else begin
                s = (pos == 0);
                if ($urandom_range(0, 11) == 0) s = ~s;
                step(1, s, $urandom_range(0, 15));
                pos = (pos + 1) % 4;
            end
            if (i == 300) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/tdm_demux_4ch_4bit.md
Name: tdm_demux_4ch_4bit

Overview:
Time-division demultiplexer, receive side of the 4-channel, 4-bit select path. Accepts a serial stream of 4-bit slots (one channel per beat, slot 0 flagged by in_sof). Reassembles each 4-beat frame into four parallel channel registers, updated atomically with a one-cycle frame strobe. Tracks frame alignment and reports sync loss.

Parameters:
WIDTH, 4, bit width of each slot/channel
ERR_CNT_W, 8, width of saturating sync-error counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
in_valid  input  1  in_data/in_sof valid this cycle (beat)
in_data  input  WIDTH  slot payload
in_sof  input  1  start of frame; marks slot 0, qualified by in_valid
out_a  output  WIDTH  channel 0 (slot 0) data
out_b  output  WIDTH  channel 1 (slot 1) data
out_c  output  WIDTH  channel 2 (slot 2) data
out_d  output  WIDTH  channel 3 (slot 3) data
out_valid  output  1  one-cycle strobe: out_a..out_d just updated
locked  output  1  frame alignment acquired
slot  output  2  next expected slot index
sync_err  output  1  one-cycle pulse on alignment violation
err_cnt  output  ERR_CNT_W  saturating count of sync_err pulses

Behaviour:
- Reset (rst_n low at clk edge): out_a..out_d=0, out_valid=0, locked=0, slot=0, sync_err=0, err_cnt=0, shadow regs=0, FSM=HUNT. Reset dominates all other inputs, mid-frame included; partial frame discarded.
- Beat = cycle with in_valid=1. Cycles with in_valid=0: no state change except out_valid/sync_err return to 0.
- FSM states HUNT, LOCKED.
- HUNT: beats with in_sof=0 ignored. Beat with in_sof=1: capture in_data into shadow0, slot<=1, locked<=1, go LOCKED.
- LOCKED, beat with slot=1/2 and in_sof=0: capture into shadow1/shadow2, slot increments.
- LOCKED, beat with slot=3 and in_sof=0: out_a<=shadow0, out_b<=shadow1, out_c<=shadow2, out_d<=in_data, all in the same edge; out_valid=1 for that following cycle; slot<=0.
- LOCKED, beat with slot=0 and in_sof=1: capture shadow0, slot<=1 (normal frame start).
- LOCKED, beat with slot=0 and in_sof=0 (missing SOF): sync_err pulse, beat discarded, locked<=0, slot<=0, go HUNT.
- LOCKED, beat with slot 1..3 and in_sof=1 (early SOF): sync_err pulse, partial frame discarded (no out_valid), beat taken as slot 0 of new frame (shadow0 captured, slot<=1), remain LOCKED.
- Latency: slot-3 beat at edge N -> outputs and out_valid visible after edge N; minimum 4 beats per frame; back-to-back frames give out_valid every 4th beat.
- out_a..out_d hold last complete frame until next completed frame; never partially updated.
- err_cnt increments on each sync_err pulse, saturates at all-ones (no wrap).
- sync_err and out_valid never both 1 in same cycle (mutually exclusive conditions).
- All outputs registered; no combinational input-to-output paths.

Test Plan:
- Reset then 4 beats {sof=1 data=1, 2, 3, 4} contiguous -> after 4th edge out_a..d=1,2,3,4, out_valid=1 one cycle, locked=1, slot=0, err_cnt=0.
- HUNT: beats 0xF,0xE with sof=0 then frame {sof 5,6,7,8} -> first two ignored, outputs=5,6,7,8, no sync_err.
- Frame {sof 1,2} then beat sof=1 data 9, then A,B,C -> sync_err pulse on 3rd beat, err_cnt=1, no out_valid until outputs=9,A,B,C.
- Complete frame 1,2,3,4 then beat data 5 with sof=0 -> sync_err, locked=0, HUNT; outputs stay 1,2,3,4.
- Frame with in_valid gaps (idle cycles between each beat) 3,0,F,6 -> outputs=3,0,F,6, single out_valid pulse after last beat.
- rst_n low after 2 beats of a frame, then new frame 7,7,7,7 -> all outputs 0 after reset, then 7,7,7,7; 300 forced sync errors -> err_cnt=255 (saturated).
